// File: rtl/fft_pkg.sv
// Shared constants, loader state encoding and sample packing for the FFT frame path.
// Pure declarations; no logic.
package fft_pkg;
    localparam int FFT_N  = 1024;
    localparam int HALF_N = 512;
    localparam int AW     = 11;
    localparam int DW     = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_FLUSH = 3'd3,
        S_KICK  = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    function automatic logic [2*DW-1:0] pack_iq(input logic [DW-1:0] re, input logic [DW-1:0] im);
        return {re, im};
    endfunction
endpackage

// File: rtl/bank_write_port.sv
// Registered write driver for one single-port BSRAM bank.
// Latency: strobe and address/data appear the cycle after wr_en. No backpressure; RAM always accepts.
module bank_write_port #(
    parameter int AW = 11,
    parameter int DW = 16,
    parameter int IW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [2*DW-1:0]   wr_dat,
    output logic              ce,
    output logic              wre,
    output logic              oce,
    output logic [AW-1:0]     ad,
    output logic [2*DW-1:0]   din
);
    logic              wr_q, wr_d;
    logic [AW-1:0]     ad_q, ad_d;
    logic [2*DW-1:0]   din_q, din_d;

    // Address and data hold their last value between writes to avoid needless toggling.
    always_comb begin
        wr_d  = wr_en;
        ad_d  = ad_q;
        din_d = din_q;
        if (wr_en) begin
            ad_d  = {{(AW-IW){1'b0}}, wr_idx};
            din_d = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            ad_q  <= '0;
            din_q <= '0;
        end else begin
            wr_q  <= wr_d;
            ad_q  <= ad_d;
            din_q <= din_d;
        end
    end

    assign ce  = wr_q;
    assign wre = wr_q;
    assign oce = wr_q;
    assign ad  = ad_q;
    assign din = din_q;
endmodule

// File: rtl/fft_frame_loader.sv
// Loads a 1024-sample complex frame into the two FFT banks, then runs the fft1024 start/finish handshake.
// Latency: write strobe 1 cycle after accept, fft_start 2 cycles after the final accept. in_ready low outside LOAD0/LOAD1.
module fft_frame_loader #(
    parameter int HALF_N = 512,
    parameter int AW     = 11,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_re,
    input  logic [DW-1:0]     in_im,
    input  logic              in_last,
    output logic              oce0,
    output logic              ce0,
    output logic              wre0,
    output logic [AW-1:0]     ad0,
    output logic [2*DW-1:0]   din0,
    output logic              oce1,
    output logic              ce1,
    output logic              wre1,
    output logic [AW-1:0]     ad1,
    output logic [2*DW-1:0]   din1,
    output logic              sel,
    output logic              fft_start,
    input  logic              fft_finish,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import fft_pkg::*;

    localparam int CW = $clog2(2*HALF_N);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            accept, bad_last, wr_en;
    logic [2*DW-1:0] wr_dat;

    assign accept   = in_valid && in_ready;
    // A premature in_last drops the sample and aborts the frame; a missing one on the final sample is harmless.
    assign bad_last = accept && in_last && (cnt_q != CW'(2*HALF_N-1));
    assign wr_en    = accept && !bad_last;
    assign wr_dat   = pack_iq(in_re, in_im);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        in_ready  = 1'b0;
        sel       = 1'b0;
        fft_start = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_LOAD0;
                    cnt_d   = '0;
                end
            end
            S_LOAD0, S_LOAD1: begin
                in_ready = 1'b1;
                if (bad_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == S_LOAD0 && cnt_q == CW'(HALF_N-1)) begin
                        state_d = S_LOAD1;
                    end else if (state_q == S_LOAD1 && cnt_q == CW'(2*HALF_N-1)) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                    end
                end
            end
            S_FLUSH: state_d = S_KICK;
            S_KICK: begin
                sel       = 1'b1;
                fft_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                sel = 1'b1;
                if (fft_finish) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    // The counter MSB is the bank select: samples 0..HALF_N-1 land in bank0.
    bank_write_port #(.AW(AW), .DW(DW), .IW(CW-1)) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en && !cnt_q[CW-1]),
        .wr_idx (cnt_q[CW-2:0]),
        .wr_dat (wr_dat),
        .ce     (ce0),
        .wre    (wre0),
        .oce    (oce0),
        .ad     (ad0),
        .din    (din0)
    );

    bank_write_port #(.AW(AW), .DW(DW), .IW(CW-1)) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en && cnt_q[CW-1]),
        .wr_idx (cnt_q[CW-2:0]),
        .wr_dat (wr_dat),
        .ce     (ce1),
        .wre    (wre1),
        .oce    (oce1),
        .ad     (ad1),
        .din    (din1)
    );
endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: the driver predicts bank writes and handshake pulses
// from sample index arithmetic; a negedge monitor compares them against the DUT outputs.
module tb_fft_frame_loader;
    localparam int FRAME = 1024;
    localparam int HALF  = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        in_last = 1'b0;
    logic        oce0, ce0, wre0, oce1, ce1, wre1;
    logic [10:0] ad0, ad1;
    logic [31:0] din0, din1;
    logic        sel, fft_start, busy, done, err;
    logic        fft_finish = 1'b0;

    fft_frame_loader dut (
        .clk(clk), .rst_n(rst_n), .arm(arm),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .oce0(oce0), .ce0(ce0), .wre0(wre0), .ad0(ad0), .din0(din0),
        .oce1(oce1), .ce1(ce1), .wre1(wre1), .ad1(ad1), .din1(din1),
        .sel(sel), .fft_start(fft_start), .fft_finish(fft_finish),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          bank;
        int          addr;
        logic [31:0] data;
        int          due;
    } wr_t;

    wr_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  start_due = -1;
    int  done_due = -1;
    int  err_due = -1;
    int  start_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_strobe(input int bank, input logic ce, input logic wre, input logic oce,
                                input logic [10:0] ad, input logic [31:0] din);
        wr_t e;
        if (sb.size() == 0) begin
            chk("unexpected_write", 64'(bank), 64'(99));
            return;
        end
        e = sb.pop_front();
        chk("write_strobes", 64'({ce, wre, oce}), 64'(3'b111));
        chk("write_cycle", 64'(cyc), 64'(e.due));
        chk("write_target", {31'(bank), ad, din[21:0]}, {31'(e.bank), 11'(e.addr), e.data[21:0]});
        chk("write_data", 64'(din), 64'(e.data));
    endtask

    // Monitor: everything sampled half a cycle after the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ce0 || wre0 || oce0) check_strobe(0, ce0, wre0, oce0, ad0, din0);
            if (ce1 || wre1 || oce1) check_strobe(1, ce1, wre1, oce1, ad1, din1);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_write", 64'(sb[0].addr), 64'(-1));
                void'(sb.pop_front());
            end
            if (fft_start || cyc == start_due) begin
                chk("fft_start_timing", 64'(fft_start), 64'(cyc == start_due));
                chk("sel_at_kick", 64'(sel), 64'(1));
                if (fft_start) start_cnt++;
            end
            if (done || cyc == done_due) chk("done_timing", 64'(done), 64'(cyc == done_due));
            if (err || cyc == err_due) chk("err_timing", 64'(err), 64'(cyc == err_due));
        end
    end

    // Arms the loader and streams samples until 'limit' accepts or an in_last error at err_at.
    task automatic send_frame(input int gap_pct, input int err_at, input int limit, output int stalls);
        int idx = 0;
        int guard = 0;
        stalls = 0;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        while (idx < limit && guard < 20000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            if (gap_pct == 0) begin
                in_re = 16'(idx);
                in_im = 16'(-idx);
            end else begin
                in_re = 16'($urandom);
                in_im = 16'($urandom);
            end
            in_last = (idx == err_at) || (idx == FRAME-1 && $urandom_range(1) == 1);
            arm = ($urandom_range(9) == 0);
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                if (idx == err_at) begin
                    err_due = cyc + 1;
                    idx = limit;
                end else begin
                    sb.push_back('{bank: idx / HALF, addr: idx % HALF, data: {in_re, in_im}, due: cyc + 1});
                    if (idx == FRAME-1) start_due = cyc + 2;
                    idx++;
                end
            end
            @(negedge clk);
            guard++;
        end
        chk("frame_guard", 64'(guard < 20000), 64'(1));
        in_valid = 1'b0;
        in_last = 1'b0;
        arm = 1'b0;
    endtask

    // Waits for fft_start, holds fft_finish low, then finishes the transform.
    task automatic run_fft(input int hold);
        int k = 0;
        while (!fft_start && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", 64'(fft_start), 64'(1));
        repeat (hold) begin
            @(negedge clk);
            in_valid = ($urandom_range(1) == 1);
        end
        chk("sel_in_wait", 64'({sel, in_ready, busy}), 64'(3'b101));
        in_valid = 1'b0;
        fft_finish = 1'b1;
        done_due = cyc + 1;
        @(negedge clk);
        fft_finish = 1'b0;
        chk("sel_after_finish", 64'(sel), 64'(0));
        @(negedge clk);
        chk("idle_after_done", 64'({busy, sel}), 64'(0));
    endtask

    initial begin
        int stalls;
        #1;
        chk("reset_outputs", 64'({in_ready, ce0, wre0, oce0, ce1, wre1, oce1, sel, fft_start, busy, done, err}), 64'(0));
        chk("reset_addr_data", {ad0, ad1, din0[20:0]}, 64'(0));
        #20 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stray finish in IDLE must not produce done.
        fft_finish = 1'b1;
        @(negedge clk);
        fft_finish = 1'b0;
        repeat (2) @(negedge clk);
        chk("finish_ignored_idle", 64'({busy, done}), 64'(0));

        // Back-to-back frame with re=i, im=-i and a long transform.
        send_frame(0, -1, FRAME, stalls);
        chk("no_stall_b2b", 64'(stalls), 64'(0));
        run_fft(5000);

        // Randomly gapped frame.
        send_frame(30, -1, FRAME, stalls);
        chk("no_stall_gapped", 64'(stalls), 64'(0));
        run_fft(20);

        // Premature in_last on sample 700.
        send_frame(10, 700, FRAME, stalls);
        chk("idle_after_err", 64'({busy, in_ready, sel}), 64'(0));
        repeat (4) @(negedge clk);

        // Reset in LOAD1 at sample 800, then a clean frame.
        send_frame(0, -1, 800, stalls);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({in_ready, ce0, wre0, ce1, wre1, oce1, sel, fft_start, busy, done, err}), 64'(0));
        sb.delete();
        start_due = -1;
        err_due = -1;
        #12 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start_cnt = 0;
        send_frame(10, -1, FRAME, stalls);
        run_fft(10);
        chk("single_start_after_reset", 64'(start_cnt), 64'(1));
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
